// File: rtl/cam_pattern_gen.sv
// Camera-stream pattern source: programmable frames with sof/eol/eof markers and blanking.
// Define CAM_PATTERN_GEN_CRC_EN to add a per-frame CRC-16/CCITT on o_frame_crc.
`timescale 1ns/1ps
module cam_pattern_gen #(
    parameter int PIX_W     = 8,
    parameter int FRAME_W   = 8,
    parameter int FRAME_H   = 8,
    parameter int LINE_GAP  = 2,
    parameter int FRAME_GAP = 16,
    parameter int CNT_W     = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic [1:0]       i_mode,
    input  logic [PIX_W-1:0] i_seed,
    input  logic [CNT_W-1:0] i_num_frames,
    output logic             o_busy,
    output logic             o_cam_valid,
    output logic             o_cam_sof,
    output logic             o_cam_eol,
    output logic             o_cam_eof,
    output logic [PIX_W-1:0] o_cam_pixel,
    output logic [CNT_W-1:0] o_frames_done,
    output logic             o_done,
    output logic [15:0]      o_frame_crc
);
    localparam int X_W     = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam int Y_W     = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;
    localparam int GAP_MAX = (LINE_GAP > FRAME_GAP) ? LINE_GAP : FRAME_GAP;
    localparam int GAP_W   = $clog2(GAP_MAX + 1);
    localparam logic [X_W-1:0]   X_LAST    = X_W'(FRAME_W - 1);
    localparam logic [Y_W-1:0]   Y_LAST    = Y_W'(FRAME_H - 1);
    localparam logic [GAP_W-1:0] LGAP_LAST = GAP_W'(LINE_GAP - 1);
    localparam logic [GAP_W-1:0] FGAP_LAST = GAP_W'(FRAME_GAP - 1);

    typedef enum logic [1:0] {IDLE, LINE, LGAP, FGAP} state_t;

    state_t           r_state, w_nextState;
    logic [X_W-1:0]   r_x;
    logic [Y_W-1:0]   r_y;
    logic [GAP_W-1:0] r_gap;
    logic [PIX_W-1:0] r_idx;
    logic [1:0]       r_mode;
    logic [PIX_W-1:0] r_seed;
    logic [CNT_W-1:0] r_numFrames;
    logic [15:0]      r_lfsr;
    logic             r_stopPend;
    logic             r_ending;

    logic             w_start, w_beat, w_lastX, w_lastY, w_lastBeat, w_finish;
    logic             w_sof, w_eol, w_eof;
    logic [PIX_W-1:0] w_pixel;
    logic [CNT_W-1:0] w_framesInc;
    logic [15:0]      w_lfsrNext;

    // A run is not restartable until its done pulse has gone out.
    assign w_start     = i_start && (r_state == IDLE) && !o_busy;
    assign w_beat      = (r_state == LINE);
    assign w_lastX     = (r_x == X_LAST);
    assign w_lastY     = (r_y == Y_LAST);
    assign w_lastBeat  = w_beat && w_lastX && w_lastY;
    assign w_framesInc = o_frames_done + CNT_W'(1);
    assign w_finish    = w_lastBeat && (((r_numFrames != '0) && (w_framesInc == r_numFrames))
                                        || r_stopPend || i_stop);
    assign w_lfsrNext  = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: if (w_start) w_nextState = LINE;
            LINE: begin
                if (w_lastX) begin
                    if (!w_lastY)      w_nextState = (LINE_GAP == 0) ? LINE : LGAP;
                    else if (w_finish) w_nextState = IDLE;
                    else               w_nextState = FGAP;
                end
            end
            LGAP: if (r_gap == LGAP_LAST) w_nextState = LINE;
            FGAP: if (r_gap == FGAP_LAST) w_nextState = LINE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        w_sof   = w_beat && (r_x == '0) && (r_y == '0);
        w_eol   = w_beat && w_lastX;
        w_eof   = w_lastBeat;
        w_pixel = '0;
        if (w_beat) begin
            case (r_mode)
                2'd0:    w_pixel = r_seed + r_idx;
                2'd1:    w_pixel = r_seed;
                2'd2:    w_pixel = {PIX_W{r_x[0] ^ r_y[0]}};
                default: w_pixel = r_lfsr[PIX_W-1:0];
            endcase
        end
    end

    // Beats computed from state in cycle N are presented from edge N+1.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_cam_valid   <= 1'b0;
            o_cam_sof     <= 1'b0;
            o_cam_eol     <= 1'b0;
            o_cam_eof     <= 1'b0;
            o_cam_pixel   <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_frames_done <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_gap         <= '0;
            r_idx         <= '0;
            r_mode        <= '0;
            r_seed        <= '0;
            r_numFrames   <= '0;
            r_lfsr        <= 16'hACE1;
            r_stopPend    <= 1'b0;
            r_ending      <= 1'b0;
        end else begin
            o_cam_valid <= w_beat;
            o_cam_sof   <= w_sof;
            o_cam_eol   <= w_eol;
            o_cam_eof   <= w_eof;
            o_cam_pixel <= w_pixel;
            o_done      <= 1'b0;
            if (r_ending) begin
                o_busy   <= 1'b0;
                o_done   <= 1'b1;
                r_ending <= 1'b0;
            end
            if ((r_state != IDLE) && i_stop) r_stopPend <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_mode        <= i_mode;
                        r_seed        <= i_seed;
                        r_numFrames   <= i_num_frames;
                        r_lfsr        <= 16'(i_seed) | 16'h0001;
                        o_frames_done <= '0;
                        o_busy        <= 1'b1;
                        r_stopPend    <= 1'b0;
                        r_x           <= '0;
                        r_y           <= '0;
                        r_idx         <= '0;
                    end
                end
                LINE: begin
                    r_idx  <= r_idx + PIX_W'(1);
                    r_lfsr <= w_lfsrNext;
                    r_gap  <= '0;
                    if (w_lastX) begin
                        r_x <= '0;
                        if (w_lastY) begin
                            r_y           <= '0;
                            r_idx         <= '0;
                            o_frames_done <= w_framesInc;
                            if (w_finish) begin
                                r_ending   <= 1'b1;
                                r_stopPend <= 1'b0;
                            end
                        end else begin
                            r_y <= r_y + Y_W'(1);
                        end
                    end else begin
                        r_x <= r_x + X_W'(1);
                    end
                end
                default: r_gap <= r_gap + GAP_W'(1);
            endcase
        end
    end

`ifdef CAM_PATTERN_GEN_CRC_EN
    function automatic logic [15:0] crcStep(input logic [15:0] crcIn, input logic [PIX_W-1:0] data);
        logic [15:0] c;
        logic        fb;
        c = crcIn;
        for (int i = PIX_W - 1; i >= 0; i--) begin
            fb = c[15] ^ data[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    logic [15:0] r_crc;
    logic [15:0] w_crcNext;

    // Runs one beat behind the pixel outputs, so the frame result lands the edge after eof.
    assign w_crcNext = crcStep(o_cam_sof ? 16'hFFFF : r_crc, o_cam_pixel);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_crc       <= 16'hFFFF;
            o_frame_crc <= '0;
        end else if (o_cam_valid) begin
            r_crc <= w_crcNext;
            if (o_cam_eof) o_frame_crc <= w_crcNext;
        end
    end
`else
    assign o_frame_crc = '0;
`endif

endmodule

// File: tb/tb_cam_pattern_gen.sv
// Scoreboard bench for cam_pattern_gen: a frame-level model queues expected beats, a monitor checks them.
`timescale 1ns/1ps
module tb_cam_pattern_gen;
    localparam int PIX_W     = 8;
    localparam int FRAME_W   = 8;
    localparam int FRAME_H   = 8;
    localparam int LINE_GAP  = 2;
    localparam int FRAME_GAP = 16;
    localparam int CNT_W     = 16;
    localparam int MASK      = (1 << PIX_W) - 1;

    logic             clk = 1'b0;
    logic             rst, start, stop;
    logic [1:0]       mode;
    logic [PIX_W-1:0] seed;
    logic [CNT_W-1:0] numFrames;
    logic             busy, camValid, camSof, camEol, camEof, done;
    logic [PIX_W-1:0] camPixel;
    logic [CNT_W-1:0] framesDone;
    logic [15:0]      frameCrc;

    cam_pattern_gen #(
        .PIX_W(PIX_W), .FRAME_W(FRAME_W), .FRAME_H(FRAME_H),
        .LINE_GAP(LINE_GAP), .FRAME_GAP(FRAME_GAP), .CNT_W(CNT_W)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop),
        .i_mode(mode), .i_seed(seed), .i_num_frames(numFrames),
        .o_busy(busy), .o_cam_valid(camValid), .o_cam_sof(camSof),
        .o_cam_eol(camEol), .o_cam_eof(camEof), .o_cam_pixel(camPixel),
        .o_frames_done(framesDone), .o_done(done), .o_frame_crc(frameCrc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PIX_W-1:0] pixel;
        logic             sof, eol, eof;
        logic [CNT_W-1:0] frames;
        int               delta;
        logic [15:0]      crc;
    } beat_t;

    beat_t       expQ[$];
    beat_t       mb;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          prevBeatCyc = 0;
    int          lastEofCyc = 0;
    int          runBeats = 0;
    int          doneSeen = 0;
    logic        crcPending = 1'b0;
    logic [15:0] crcExp = '0;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    function automatic int lfsrStep(input int v);
        int fb;
        fb = (v ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
        return ((v >> 1) | (fb << 15)) & 'hFFFF;
    endfunction

    function automatic int crcPix(input int crcIn, input int pix);
        int c, fb;
        c = crcIn;
        for (int b = PIX_W - 1; b >= 0; b--) begin
            fb = ((c >> 15) ^ (pix >> b)) & 1;
            c  = (c << 1) & 'hFFFF;
            if (fb != 0) c = c ^ 'h1021;
        end
        return c;
    endfunction

    // Expected stream for a whole run, straight from the frame/pattern rules.
    task automatic genRun(input int m, input int s, input int nFrames);
        beat_t b;
        int    sm, lfsr, crc, idx, pix;
        sm   = s & MASK;
        lfsr = (sm & 'hFFFF) | 1;
        for (int f = 0; f < nFrames; f++) begin
            crc = 'hFFFF;
            for (int y = 0; y < FRAME_H; y++) begin
                for (int x = 0; x < FRAME_W; x++) begin
                    idx = y * FRAME_W + x;
                    case (m)
                        0:       pix = (sm + idx) & MASK;
                        1:       pix = sm;
                        2:       pix = (((x ^ y) & 1) != 0) ? MASK : 0;
                        default: pix = lfsr & MASK;
                    endcase
                    lfsr = lfsrStep(lfsr);
                    crc  = crcPix(crc, pix);
                    b.pixel = PIX_W'(pix);
                    b.sof   = (x == 0) && (y == 0);
                    b.eol   = (x == FRAME_W - 1);
                    b.eof   = (x == FRAME_W - 1) && (y == FRAME_H - 1);
                    b.frames = CNT_W'(b.eof ? f + 1 : f);
                    if (x != 0 || (f == 0 && y == 0)) b.delta = 1;
                    else if (y != 0)                  b.delta = LINE_GAP + 1;
                    else                              b.delta = FRAME_GAP + 1;
`ifdef CAM_PATTERN_GEN_CRC_EN
                    b.crc = 16'(crc);
`else
                    b.crc = 16'h0;
`endif
                    expQ.push_back(b);
                end
            end
        end
    endtask

    // Monitor: pops one expected beat per valid output beat.
    always @(negedge clk) begin
        if (rst) begin
            crcPending = 1'b0;
        end else begin
            if (crcPending) begin
                checkOutput("frame_crc", frameCrc, crcExp);
                crcPending = 1'b0;
            end
            if (done) doneSeen++;
            if (camValid) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_beat actual=pixel %0h expected=no beat", camPixel);
                end else begin
                    mb = expQ.pop_front();
                    checkOutput("pixel", camPixel, mb.pixel);
                    checkOutput("sof", camSof, mb.sof);
                    checkOutput("eol", camEol, mb.eol);
                    checkOutput("eof", camEof, mb.eof);
                    checkOutput("frames_done", framesDone, mb.frames);
                    checkOutput("busy_in_run", busy, 1);
                    checkOutput("beat_spacing", cyc - prevBeatCyc, mb.delta);
                    if (mb.eof) begin
                        lastEofCyc = cyc;
                        crcPending = 1'b1;
                        crcExp     = mb.crc;
                    end
                end
                prevBeatCyc = cyc;
                runBeats++;
            end else begin
                checkOutput("idle_markers", {29'd0, camSof, camEol, camEof}, 0);
            end
        end
    end

    task automatic waitBeats(input int n);
        for (int i = 0; i < 5000; i++) begin
            if (runBeats >= n) break;
            @(negedge clk);
        end
    endtask

    task automatic pulseStart(input int m, input int s, input int n);
        @(negedge clk);
        mode        = 2'(m);
        seed        = PIX_W'(s);
        numFrames   = CNT_W'(n);
        start       = 1'b1;
        prevBeatCyc = cyc + 1;
        runBeats    = 0;
        @(negedge clk);
        start     = 1'b0;
        mode      = 2'($urandom_range(0, 3));
        seed      = PIX_W'($urandom);
        numFrames = CNT_W'($urandom_range(1, 9));
    endtask

    // One run; stopAt>=0 means continuous mode stopped after that many beats.
    task automatic applyStimulus(input int m, input int s, input int n, input int stopAt, input bit pokeStart);
        int  runFrames, doneBefore;
        bit  got;
        runFrames  = (n == 0) ? 2 : n;
        doneBefore = doneSeen;
        genRun(m, s, runFrames);
        pulseStart(m, s, n);
        if (pokeStart) begin
            waitBeats(10);
            @(negedge clk);
            mode  = 2'((m + 1) % 4);
            seed  = PIX_W'(s + 77);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        if (stopAt >= 0) begin
            waitBeats(stopAt);
            @(negedge clk);
            stop = 1'b1;
            @(negedge clk);
            stop = 1'b0;
        end
        got = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("[TB] FAIL done_timeout actual=no done expected=done within 4000 cycles");
            expQ.delete();
        end else begin
            checkOutput("done_latency", cyc - lastEofCyc, 1);
            checkOutput("busy_at_done", busy, 0);
            checkOutput("frames_at_done", framesDone, runFrames);
            checkOutput("scoreboard_drained", expQ.size(), 0);
            @(negedge clk);
            checkOutput("done_width", done, 0);
            checkOutput("done_count", doneSeen - doneBefore, 1);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_valid"}, camValid, 0);
        checkOutput({tag, "_sof"}, camSof, 0);
        checkOutput({tag, "_eol"}, camEol, 0);
        checkOutput({tag, "_eof"}, camEof, 0);
        checkOutput({tag, "_pixel"}, camPixel, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_frames"}, framesDone, 0);
        checkOutput({tag, "_crc"}, frameCrc, 0);
    endtask

    initial begin
        int rs, doneBefore;
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        mode = '0; seed = '0; numFrames = '0;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;
        $display("[TB] directed runs");
        applyStimulus(0, 0, 1, -1, 1'b0);
        applyStimulus(0, 'hF0, 1, -1, 1'b0);
        applyStimulus(2, int'($urandom), 3, -1, 1'b0);
        applyStimulus(1, 0, 2, -1, 1'b0);
        applyStimulus(3, int'($urandom), 2, -1, 1'b0);
        applyStimulus(int'($urandom_range(0, 3)), int'($urandom), 0, 64 + 20, 1'b1);
        $display("[TB] randomized runs");
        for (int k = 0; k < 4; k++)
            applyStimulus(int'($urandom_range(0, 3)), int'($urandom), int'($urandom_range(1, 2)), -1, 1'b0);

        $display("[TB] reset mid-frame");
        doneBefore = doneSeen;
        genRun(0, 5, 1);
        pulseStart(0, 5, 1);
        waitBeats(3 * FRAME_W + 3);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkAllZero("midreset");
        expQ.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("no_done_after_reset", doneSeen - doneBefore, 0);
        checkOutput("idle_after_reset", {30'd0, busy, camValid}, 0);
        rs = int'($urandom);
        applyStimulus(0, rs, 1, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cam_pattern_gen.md
Name: cam_pattern_gen

Overview:
- Synthesisable, parametrised camera-stream source that drives the cam_valid/cam_sof/cam_pixel sensor interface of the dashcam SoC.
- Replaces hand-written frame stimulus in benches and FPGA bring-up.
- Emits programmable frame sizes, multiple pixel patterns, line/frame blanking and multi-frame or continuous runs.
- Adds end-of-line and end-of-frame markers that the single fixed-size incrementing frame lacks.

Parameters:
PIX_W, 8, pixel width in bits (1..16)
FRAME_W, 8, pixels per line (>=1)
FRAME_H, 8, lines per frame (>=1)
LINE_GAP, 2, idle cycles between lines of one frame (0 = back-to-back)
FRAME_GAP, 16, idle cycles between frames (>=1)
CNT_W, 16, width of frame counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle pulse; begins a run (ignored while busy)
stop  in  1  one-cycle pulse; ends run after current frame
mode  in  2  0 incrementing, 1 constant, 2 checker, 3 LFSR; latched at start
seed  in  PIX_W  pattern seed; latched at start
num_frames  in  CNT_W  frames per run, 0 = continuous; latched at start
busy  out  1  run in progress
cam_valid  out  1  pixel beat valid
cam_sof  out  1  first beat of frame
cam_eol  out  1  last beat of line
cam_eof  out  1  last beat of frame
cam_pixel  out  PIX_W  pixel data
frames_done  out  CNT_W  frames completed in current/last run
done  out  1  one-cycle pulse at run end
frame_crc  out  16  CRC of last completed frame (see Optional Feature)

Behaviour:
- All outputs registered; while rst is high all outputs are 0, FSM is in IDLE and the LFSR is loaded with 16'hACE1.
- FSM states: IDLE, LINE, LGAP, FGAP.
- IDLE + start: latch mode/seed/num_frames, clear frames_done, set busy, go to LINE. First beat (cam_valid=1, cam_sof=1, x=y=0) appears on the clock edge after start is sampled.
- LINE: one beat per cycle for FRAME_W cycles; x counts 0..FRAME_W-1.
  - Last beat of line asserts cam_eol.
  - If y<FRAME_H-1: y++, go to LGAP (or stay in LINE when LINE_GAP=0).
  - Else the beat also asserts cam_eof, frames_done increments on that edge, and control goes to FGAP or finishes.
- LGAP: cam_valid=0 for exactly LINE_GAP cycles, then LINE.
- FGAP: cam_valid=0 for exactly FRAME_GAP cycles, then LINE with the next frame's sof.
- Run finishes on the eof beat when either:
  - num_frames!=0 and the incremented frames_done equals num_frames, or
  - a stop is pending.
  - On the next edge: busy=0, done=1 for one cycle, FSM to IDLE. No FGAP after the final frame.
- stop: sampled only while busy; sets a pending flag cleared at run end. A frame is never truncated. start and stop together in IDLE: start accepted, stop discarded.
- start while busy: ignored.
- cam_pixel, with idx = y*FRAME_W+x:
  - mode 0: (seed+idx) mod 2^PIX_W.
  - mode 1: seed.
  - mode 2: all-ones if x[0]^y[0], else 0.
  - mode 3: low PIX_W bits of a 16-bit Fibonacci LFSR (taps 16,14,13,11). Reseeded at start to {seed,…} zero-extended with bit0 forced 1, advanced once per valid beat and continued across frames.
- cam_sof/cam_eol/cam_eof are 0 whenever cam_valid=0. FRAME_W=1 gives cam_eol on every beat; FRAME_H=1 gives cam_sof and cam_eof on the same beat.
- frames_done wraps at 2^CNT_W in continuous mode.
- Reset asserted mid-frame: outputs drop to 0 immediately; no done pulse.

Optional Feature:
- Macro CAM_PATTERN_GEN_CRC_EN.
- Defined: a CRC-16/CCITT engine (poly 0x1021, init 0xFFFF, MSB-first, PIX_W bits per beat) runs over every valid pixel.
  - Reinitialised on sof.
  - frame_crc updates on the edge after each eof beat and holds until the next eof; 0 after reset.
- Undefined: no CRC logic; frame_crc tied to 0.

Test Plan:
- Defaults, mode 0, seed 0, num_frames 1, start → 64 beats with pixels 0..63; sof on beat 0; eol on every 8th beat; eof on beat 63; 2-cycle gaps between lines; frames_done=1; done pulses one cycle after eof; busy low.
- Mode 0, seed 8'hF0 → pixel 16 = 8'h00 (wrap-around); line/frame markers unchanged.
- num_frames 3, mode 2 → 3 sof pulses spaced 64+7*2+16 = 94 cycles apart; first pixel of each line alternates 0/FF; frames_done counts 1,2,3; single done pulse.
- num_frames 0, stop pulsed mid-frame 2 → frame 2 completes fully, then done; frames_done=2; a start pulsed while busy causes no effect.
- rst asserted during line 4 → all outputs 0 immediately; a later start restarts cleanly at sof, pixel=seed.
- CAM_PATTERN_GEN_CRC_EN, mode 1, seed 0 → frame_crc equals reference CRC-16/CCITT of 64 zero bytes (0x7B2C… per golden model); identical across frames; 0 when macro is undefined.
